// File: rtl/axi_id_slot_alloc_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_id_slot_alloc_if
// Description : Request/response handshake bundle for the AXI ID slot allocator.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_id_slot_alloc_if #(
    parameter int SLV_ID_WIDTH = 4,
    parameter int MST_ID_WIDTH = 2
);
    logic                    req_valid_i;
    logic [SLV_ID_WIDTH-1:0] req_id_i;
    logic                    req_ready_o;
    logic [MST_ID_WIDTH-1:0] req_slot_o;
    logic                    rsp_valid_i;
    logic [MST_ID_WIDTH-1:0] rsp_slot_i;
    logic                    rsp_err_o;
    logic                    idle_o;
    logic                    full_o;

    modport slave (
        input  req_valid_i, req_id_i, rsp_valid_i, rsp_slot_i,
        output req_ready_o, req_slot_o, rsp_err_o, idle_o, full_o
    );

    modport master (
        output req_valid_i, req_id_i, rsp_valid_i, rsp_slot_i,
        input  req_ready_o, req_slot_o, rsp_err_o, idle_o, full_o
    );
endinterface
`default_nettype wire

// File: rtl/axi_id_slot_alloc.sv
`default_nettype none
// ============================================================================
// Module      : axi_id_slot_alloc
// Description : Maps wide slave-port AXI IDs onto a pool of master-port ID
//               slots, counting outstanding transactions per slot.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_id_slot_alloc #(
    parameter int SLV_ID_WIDTH    = 4,
    parameter int MST_ID_WIDTH    = 2,
    parameter int MAX_TXNS_PER_ID = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_TXNS_PER_ID + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    axi_id_slot_alloc_if.slave  bus
);

    localparam int                   NUM_SLOTS = 2 ** MST_ID_WIDTH;
    localparam logic [CNT_WIDTH-1:0] C_MAX_CNT = CNT_WIDTH'(MAX_TXNS_PER_ID);
    localparam logic [CNT_WIDTH-1:0] C_ONE     = CNT_WIDTH'(1);

    logic [NUM_SLOTS-1:0]    r_vld;
    logic [SLV_ID_WIDTH-1:0] r_id  [NUM_SLOTS];
    logic [CNT_WIDTH-1:0]    r_cnt [NUM_SLOTS];
    logic                    r_rsp_err;

    logic                    w_match_hit;
    logic [MST_ID_WIDTH-1:0] w_match_idx;
    logic                    w_free_hit;
    logic [MST_ID_WIDTH-1:0] w_free_idx;
    logic                    w_ready;
    logic [MST_ID_WIDTH-1:0] w_slot;
    logic                    w_accept;
    logic [NUM_SLOTS-1:0]    w_inc;
    logic [NUM_SLOTS-1:0]    w_dec;
    logic                    w_dup_id;

    // Lookup uses registered state only, so rsp_* never reaches req_ready_o.
    always_comb begin
        w_match_hit = 1'b0;
        w_match_idx = '0;
        w_free_hit  = 1'b0;
        w_free_idx  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_vld[i] && (r_id[i] == bus.req_id_i) && !w_match_hit) begin
                w_match_hit = 1'b1;
                w_match_idx = MST_ID_WIDTH'(i);
            end
            if (!r_vld[i] && !w_free_hit) begin
                w_free_hit = 1'b1;
                w_free_idx = MST_ID_WIDTH'(i);
            end
        end

        if (w_match_hit) begin
            w_ready = (r_cnt[w_match_idx] < C_MAX_CNT);
            w_slot  = w_match_idx;
        end else begin
            w_ready = w_free_hit;
            w_slot  = w_free_idx;
        end

        w_accept = bus.req_valid_i && w_ready;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_inc[i] = w_accept && (w_slot == MST_ID_WIDTH'(i));
            w_dec[i] = bus.rsp_valid_i && (bus.rsp_slot_i == MST_ID_WIDTH'(i))
                       && r_vld[i] && (r_cnt[i] != '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld     <= '0;
            r_rsp_err <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_id[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            r_rsp_err <= bus.rsp_valid_i && !r_vld[bus.rsp_slot_i];
            for (int i = 0; i < NUM_SLOTS; i++) begin
                // Accept and release on the same slot cancel out, keeping it valid.
                if (w_inc[i] && !w_dec[i]) begin
                    if (r_vld[i]) begin
                        r_cnt[i] <= r_cnt[i] + C_ONE;
                    end else begin
                        r_vld[i] <= 1'b1;
                        r_id[i]  <= bus.req_id_i;
                        r_cnt[i] <= C_ONE;
                    end
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - C_ONE;
                    if (r_cnt[i] == C_ONE) begin
                        r_vld[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.req_slot_o  = w_slot;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.idle_o      = ~|r_vld;
    assign bus.full_o      = &r_vld;

    always_comb begin
        w_dup_id = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = i + 1; j < NUM_SLOTS; j++) begin
                if (r_vld[i] && r_vld[j] && (r_id[i] == r_id[j])) begin
                    w_dup_id = 1'b1;
                end
            end
        end
    end

    a_params_ok: assert property (@(posedge clk_i)
        (MAX_TXNS_PER_ID >= 1) && (MST_ID_WIDTH < SLV_ID_WIDTH));

    a_unique_ids: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !w_dup_id);

endmodule
`default_nettype wire

// File: tb/tb_axi_id_slot_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_id_slot_alloc
// Description : Directed self-checking bench for axi_id_slot_alloc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_id_slot_alloc;

    localparam int C_SLV_W = 4;
    localparam int C_MST_W = 2;
    localparam int C_MAX   = 4;

    logic clk_i;
    logic rst_ni;
    int   r_checks;
    int   r_errors;

    axi_id_slot_alloc_if #(
        .SLV_ID_WIDTH (C_SLV_W),
        .MST_ID_WIDTH (C_MST_W)
    ) u_if ();

    axi_id_slot_alloc #(
        .SLV_ID_WIDTH    (C_SLV_W),
        .MST_ID_WIDTH    (C_MST_W),
        .MAX_TXNS_PER_ID (C_MAX)
    ) u_dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (u_if.slave)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic drive(input logic rv, input logic [3:0] id, input logic sv, input logic [1:0] ss);
        u_if.req_valid_i = rv;
        u_if.req_id_i    = id;
        u_if.rsp_valid_i = sv;
        u_if.rsp_slot_i  = ss;
        #1;
    endtask

    initial begin
        r_checks = 0;
        r_errors = 0;
        rst_ni   = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 2'd0);
        repeat (2) step();

        check_val("rst_idle",  32'(u_if.idle_o),      32'd1);
        check_val("rst_full",  32'(u_if.full_o),      32'd0);
        check_val("rst_err",   32'(u_if.rsp_err_o),   32'd0);
        check_val("rst_ready", 32'(u_if.req_ready_o), 32'd1);
        check_val("rst_slot",  32'(u_if.req_slot_o),  32'd0);
        rst_ni = 1'b1;
        #1;

        // Same ID fills one slot up to the per-ID limit.
        drive(1'b1, 4'h5, 1'b0, 2'd0);
        check_val("id5_ready", 32'(u_if.req_ready_o), 32'd1);
        check_val("id5_slot",  32'(u_if.req_slot_o),  32'd0);
        step();
        drive(1'b0, 4'h0, 1'b0, 2'd0);
        check_val("id5_idle", 32'(u_if.idle_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'h5, 1'b0, 2'd0);
            check_val("id5_more_ready", 32'(u_if.req_ready_o), 32'd1);
            check_val("id5_more_slot",  32'(u_if.req_slot_o),  32'd0);
            step();
        end
        drive(1'b1, 4'h5, 1'b0, 2'd0);
        check_val("id5_stall", 32'(u_if.req_ready_o), 32'd0);
        step();
        drive(1'b1, 4'h5, 1'b1, 2'd0);
        check_val("id5_stall_rsp", 32'(u_if.req_ready_o), 32'd0);
        step();
        drive(1'b1, 4'h5, 1'b0, 2'd0);
        check_val("id5_resume_ready", 32'(u_if.req_ready_o), 32'd1);
        check_val("id5_resume_slot",  32'(u_if.req_slot_o),  32'd0);
        step();
        for (int k = 0; k < C_MAX; k++) begin
            drive(1'b0, 4'h0, 1'b1, 2'd0);
            step();
        end
        drive(1'b0, 4'h0, 1'b0, 2'd0);
        check_val("drain_idle", 32'(u_if.idle_o),    32'd1);
        check_val("drain_err",  32'(u_if.rsp_err_o), 32'd0);

        // Four distinct IDs take all slots in index order.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 4'(k), 1'b0, 2'd0);
            check_val("fill_ready", 32'(u_if.req_ready_o), 32'd1);
            check_val("fill_slot",  32'(u_if.req_slot_o),  32'(k - 1));
            step();
        end
        drive(1'b0, 4'h0, 1'b0, 2'd0);
        check_val("fill_full", 32'(u_if.full_o), 32'd1);
        drive(1'b1, 4'h9, 1'b0, 2'd0);
        check_val("id9_blocked", 32'(u_if.req_ready_o), 32'd0);
        drive(1'b1, 4'h9, 1'b1, 2'd2);
        check_val("id9_blocked_rsp", 32'(u_if.req_ready_o), 32'd0);
        step();
        drive(1'b1, 4'h9, 1'b0, 2'd0);
        check_val("id9_full",  32'(u_if.full_o),      32'd0);
        check_val("id9_ready", 32'(u_if.req_ready_o), 32'd1);
        check_val("id9_slot",  32'(u_if.req_slot_o),  32'd2);
        step();
        drive(1'b0, 4'h0, 1'b0, 2'd0);
        check_val("id9_refull", 32'(u_if.full_o), 32'd1);

        // Slot 1 re-used for ID 7, then accept and release in the same cycle.
        drive(1'b0, 4'h0, 1'b1, 2'd1);
        step();
        drive(1'b1, 4'h7, 1'b0, 2'd0);
        check_val("id7_slot", 32'(u_if.req_slot_o), 32'd1);
        step();
        drive(1'b1, 4'h7, 1'b1, 2'd1);
        check_val("id7_both_ready", 32'(u_if.req_ready_o), 32'd1);
        check_val("id7_both_slot",  32'(u_if.req_slot_o),  32'd1);
        step();
        drive(1'b0, 4'h0, 1'b0, 2'd0);
        check_val("id7_still_full", 32'(u_if.full_o), 32'd1);
        drive(1'b1, 4'h7, 1'b0, 2'd0);
        check_val("id7_match_ready", 32'(u_if.req_ready_o), 32'd1);
        check_val("id7_match_slot",  32'(u_if.req_slot_o),  32'd1);
        drive(1'b1, 4'h6, 1'b0, 2'd0);
        check_val("id6_blocked", 32'(u_if.req_ready_o), 32'd0);
        drive(1'b0, 4'h0, 1'b1, 2'd1);
        step();
        drive(1'b0, 4'h0, 1'b0, 2'd0);
        check_val("id7_cnt_one", 32'(u_if.full_o),    32'd0);
        check_val("id7_no_err",  32'(u_if.rsp_err_o), 32'd0);

        // Response to an unallocated slot.
        drive(1'b0, 4'h0, 1'b1, 2'd3);
        step();
        drive(1'b0, 4'h0, 1'b1, 2'd3);
        step();
        drive(1'b0, 4'h0, 1'b0, 2'd0);
        check_val("err_pulse", 32'(u_if.rsp_err_o), 32'd1);
        check_val("err_idle",  32'(u_if.idle_o),    32'd0);
        step();
        check_val("err_clear", 32'(u_if.rsp_err_o), 32'd0);
        drive(1'b1, 4'h4, 1'b0, 2'd0);
        check_val("err_nochg_ready", 32'(u_if.req_ready_o), 32'd1);
        check_val("err_nochg_slot",  32'(u_if.req_slot_o),  32'd1);
        step();
        drive(1'b0, 4'h0, 1'b0, 2'd0);
        check_val("three_full", 32'(u_if.full_o), 32'd0);
        check_val("three_idle", 32'(u_if.idle_o), 32'd0);

        // Asynchronous reset with three slots held.
        #1;
        rst_ni = 1'b0;
        #1;
        check_val("arst_idle", 32'(u_if.idle_o), 32'd1);
        check_val("arst_full", 32'(u_if.full_o), 32'd0);
        step();
        rst_ni = 1'b1;
        drive(1'b1, 4'hB, 1'b0, 2'd0);
        check_val("post_rst_ready", 32'(u_if.req_ready_o), 32'd1);
        check_val("post_rst_slot",  32'(u_if.req_slot_o),  32'd0);
        step();
        drive(1'b0, 4'h0, 1'b1, 2'd2);
        step();
        drive(1'b0, 4'h0, 1'b0, 2'd0);
        check_val("post_rst_err",  32'(u_if.rsp_err_o), 32'd1);
        check_val("post_rst_busy", 32'(u_if.idle_o),    32'd0);
        step();
        check_val("post_rst_err_clr", 32'(u_if.rsp_err_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire
